// File: rtl/mult_hs_stage_32x32.sv
// ============================================================================
// mult_hs_stage_32x32
// ----------------------------------------------------------------------------
// Handshaked issue/collect stage placed around an external combinational
// WIDTH x WIDTH unsigned multiplier. The multiplier is treated as a multicycle
// path. Operands are registered onto the multiplier inputs. The product is
// sampled SETTLE_CYCLES edges later and queued in a 2-entry result buffer.
//
// Parameters
//   WIDTH          operand width (product is 2*WIDTH)
//   SETTLE_CYCLES  edges from operand load to product capture, 1..15
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair present
//   in_ready     stage accepts the operand pair this cycle
//   in_a/in_b    operands (multiplier / multiplicand)
//   mplier_o     registered operand to the multiplier mplier input
//   mcand_o      registered operand to the multiplier mcand input
//   product_i    product from the multiplier
//   out_valid    result buffer non-empty
//   out_ready    consumer takes the head result this cycle
//   out_product  head of the result buffer
//   busy         an operation is in flight
// ============================================================================
module mult_hs_stage_32x32 #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mplier_o,
    output logic [WIDTH-1:0]     mcand_o,
    input  logic [2*WIDTH-1:0]   product_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Counter preload on accept. The FSM leaves SETTLE when the counter
    // reaches zero, so CAPTURE is reached SETTLE_CYCLES-1 edges after the
    // accept. The capture itself then lands on edge T+SETTLE_CYCLES.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]    mplier_q, mcand_q;
    logic [1:0]          count_q, count_d;
    logic                wr_ptr_q, rd_ptr_q;
    logic [2*WIDTH-1:0]  buf_q [2];

    logic                accept;
    logic                capture;
    logic                pop;
    logic                in_ready_int;

    assign accept  = in_valid && in_ready_int;
    assign capture = (state_q == CAPTURE);
    assign pop     = out_valid && out_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (SETTLE_CYCLES == 1) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                // A counter value of 1 becomes 0 on this edge, so the
                // next state is CAPTURE. A value of 0 also exits, which
                // keeps the FSM from locking up.
                if (cnt_q <= 4'd1) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_int = 1'b0;
        busy         = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready_int = (count_q != 2'd2);
                busy         = 1'b0;
            end
            SETTLE:  in_ready_int = 1'b0;
            CAPTURE: in_ready_int = 1'b0;
            default: in_ready_int = 1'b0;
        endcase
    end

    // During reset the registers already read IDLE with an empty buffer.
    // Gating with rst_n keeps in_ready low for the whole reset interval.
    assign in_ready = in_ready_int && rst_n;

    // ------------------------------------------------------------------
    // Settle counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = SETTLE_INIT;
        end else if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Operand registers. They hold until the next accept, so the product
    // stays stable across the whole settle window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier_q <= '0;
            mcand_q  <= '0;
        end else if (accept) begin
            mplier_q <= in_a;
            mcand_q  <= in_b;
        end
    end

    assign mplier_o = mplier_q;
    assign mcand_o  = mcand_q;

    // ------------------------------------------------------------------
    // Result buffer bookkeeping. A capture and a pop on the same edge leave
    // the count unchanged while both pointers advance.
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({capture, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (capture) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Buffer entries. Each entry loads only when the write pointer selects
    // it on a capture edge. A capture is only possible with count < 2, so
    // an unread entry is never overwritten.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                buf_q[gi] <= '0;
            end else if (capture && (wr_ptr_q == 1'(gi))) begin
                buf_q[gi] <= product_i;
            end
        end
    end

    assign out_valid   = (count_q != 2'd0);
    assign out_product = buf_q[rd_ptr_q];

endmodule

// File: tb/tb_mult_hs_stage_32x32.sv
module tb_mult_hs_stage_32x32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic [31:0] mplier, mcand;
    logic [63:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] popped [$];

    always #5 clk = ~clk;

    // The external combinational multiplier
    assign product = {32'd0, mplier} * {32'd0, mcand};

    mult_hs_stage_32x32 #(.WIDTH(32), .SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mplier_o    (mplier),
        .mcand_o     (mcand),
        .product_i   (product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
    );

    // Record every result actually handed to the consumer
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) popped.push_back(out_product);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n;
        vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vecs[3] = '{32'd0,         32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[4] = '{32'd1,         32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[5] = '{32'd65535,     32'd65537,     64'h0000_0000_FFFF_FFFF};

        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #20;
        check("rst_in_ready",    {63'd0, in_ready},  64'd0);
        check("rst_out_valid",   {63'd0, out_valid}, 64'd0);
        check("rst_busy",        {63'd0, busy},      64'd0);
        check("rst_mplier",      {32'd0, mplier},    64'd0);
        check("rst_mcand",       {32'd0, mcand},     64'd0);
        check("rst_out_product", out_product,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // ---- table-driven latency / value vectors ----
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(vecs[i].a, vecs[i].b);
            @(negedge clk);
            check("lat_t1_busy",  {63'd0, busy},      64'd1);
            check("lat_t1_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check("lat_t2_busy",  {63'd0, busy},      64'd1);
            check("lat_t2_valid", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check("lat_t3_valid", {63'd0, out_valid}, 64'd1);
            check("lat_t3_busy",  {63'd0, busy},      64'd0);
            check("vec_product",  out_product,        vecs[i].p);
            $display("vec %0d: %h * %h -> %h (expect %h)", i, vecs[i].a, vecs[i].b,
                     out_product, vecs[i].p);
        end
        @(negedge clk);
        check("vec_drained", {63'd0, out_valid}, 64'd0);

        // ---- backpressure: two buffered, third stalls ----
        popped.delete();
        out_ready = 1'b0;
        issue(32'd2, 32'd3);
        issue(32'd4, 32'd5);
        repeat (4) @(negedge clk);
        in_valid = 1'b1;
        in_a     = 32'd6;
        in_b     = 32'd7;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        check("bp_out_valid",   {63'd0, out_valid}, 64'd1);
        check("bp_head",        out_product,        64'd6);
        check("bp_busy",        {63'd0, busy},      64'd0);
        check("bp_mplier_hold", {32'd0, mplier},    64'd4);
        out_ready = 1'b1;
        issue(32'd6, 32'd7);
        n = 0;
        while (popped.size() < 3 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_count", 64'(popped.size()), 64'd3);
        if (popped.size() >= 3) begin
            check("bp_res0", popped[0], 64'd6);
            check("bp_res1", popped[1], 64'd20);
            check("bp_res2", popped[2], 64'd42);
        end
        $display("backpressure: %0d results collected", popped.size());

        // ---- capture and pop on the same edge ----
        @(negedge clk);
        popped.delete();
        out_ready = 1'b0;
        issue(32'd11, 32'd1);
        repeat (3) @(negedge clk);
        check("sim_first_buf", out_product, 64'd11);
        issue(32'd12, 32'd1);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;          // pop coincides with the capture edge
        @(negedge clk);
        out_ready = 1'b0;
        check("sim_valid", {63'd0, out_valid}, 64'd1);
        check("sim_head",  out_product,        64'd12);
        check("sim_pop_n", 64'(popped.size()), 64'd1);
        if (popped.size() >= 1) check("sim_pop0", popped[0], 64'd11);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("sim_final_n", 64'(popped.size()), 64'd2);
        if (popped.size() >= 2) check("sim_pop1", popped[1], 64'd12);
        check("sim_empty", {63'd0, out_valid}, 64'd0);
        $display("simultaneous capture/pop: %0d results", popped.size());

        // ---- reset in the middle of an operation ----
        out_ready = 1'b0;
        issue(32'd5, 32'd5);
        issue(32'd7, 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid",   {63'd0, out_valid}, 64'd0);
        check("mrst_busy",        {63'd0, busy},      64'd0);
        check("mrst_in_ready",    {63'd0, in_ready},  64'd0);
        check("mrst_mplier",      {32'd0, mplier},    64'd0);
        check("mrst_mcand",       {32'd0, mcand},     64'd0);
        check("mrst_out_product", out_product,        64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        popped.delete();
        out_ready = 1'b1;
        @(negedge clk);
        issue(32'd2, 32'd2);
        n = 0;
        while (popped.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        check("mrst_n", 64'(popped.size()), 64'd1);
        if (popped.size() >= 1) check("mrst_res", popped[0], 64'd4);
        $display("reset mid-op: %0d results after reset", popped.size());

        // ---- operand hold while inputs wiggle ----
        out_ready = 1'b0;
        @(negedge clk);
        issue(32'h0001_0000, 32'h0001_0000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;       // must be ignored while busy
            in_a     = $urandom;
            in_b     = $urandom;
            check("hold_mplier", {32'd0, mplier}, 64'h1_0000);
            check("hold_mcand",  {32'd0, mcand},  64'h1_0000);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_valid",   {63'd0, out_valid}, 64'd1);
        check("hold_product", out_product,        64'h0000_0001_0000_0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_a = $urandom;
            in_b = $urandom;
            check("hold_mplier2", {32'd0, mplier}, 64'h1_0000);
        end
        check("hold_head_still", out_product, 64'h0000_0001_0000_0000);
        $display("operand hold: result %h", out_product);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_hs_stage_32x32.md
Name: mult_hs_stage_32x32

Overview:
- Handshaked issue/collect stage wrapped around the combinational 32x32 unsigned multiplier.
- Accepts operand pairs on a valid/ready input and registers them onto the multiplier's operand inputs.
- Waits a fixed number of settle cycles, treating the multiplier as a multicycle path.
- Captures the 64-bit product into a 2-entry result buffer drained by a valid/ready output. This is the system-facing boundary of the multiplier datapath.

Parameters:
- WIDTH, 32: operand width; product width is 2*WIDTH.
- SETTLE_CYCLES, 2: clock edges between operand register load and product capture; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  stage accepts operand pair this cycle.
- in_a  in  WIDTH  multiplier operand.
- in_b  in  WIDTH  multiplicand operand.
- mplier_o  out  WIDTH  registered operand to multiplier mplier input.
- mcand_o  out  WIDTH  registered operand to multiplier mcand input.
- product_i  in  2*WIDTH  multiplier product output.
- out_valid  out  1  result buffer non-empty.
- out_ready  in  1  consumer takes head result this cycle.
- out_product  out  2*WIDTH  head of result buffer.
- busy  out  1  an operation is in flight (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, settle counter=0, buffer count=0, read/write pointers=0.
  - mplier_o=0, mcand_o=0, out_product=0, out_valid=0, busy=0.
  - in_ready=0 while rst_n is low.
  - Any in-flight operation and all buffered results are discarded.
- FSM states: IDLE, SETTLE, CAPTURE.
  - IDLE: in_ready = (count < 2). Accept = in_valid && in_ready. On accept: load mplier_o<=in_a, mcand_o<=in_b, counter<=SETTLE_CYCLES-1, go to SETTLE, or to CAPTURE directly if SETTLE_CYCLES==1.
  - SETTLE: in_ready=0. Decrement counter each edge; go to CAPTURE when the counter reaches 0.
  - CAPTURE: in_ready=0. On this edge write product_i into the buffer at the write pointer, increment count, and return to IDLE.
  - Operand registers hold their value until the next accept.
- Latency and throughput:
  - Accept on edge T, capture on edge T+SETTLE_CYCLES, out_valid=1 after that edge when the buffer was empty.
  - Next accept possible at edge T+SETTLE_CYCLES+1.
  - Throughput is one operation per SETTLE_CYCLES+1 cycles.
- Result buffer:
  - 2 entries, 1-bit pointers that wrap 1->0.
  - out_valid = (count != 0). out_product = entry at read pointer, registered.
  - Pop = out_valid && out_ready: advance the read pointer, decrement count.
- Boundary conditions:
  - Capture and pop on the same edge: count unchanged, both pointers advance.
  - Overflow cannot occur: accept requires count<2, at most one op is in flight, and count never increases except at capture.
  - Full buffer (count=2): in_ready=0; the stage stalls in IDLE with no loss.
  - Pop on an empty buffer: ignored.
  - in_valid while not IDLE: ignored, not accepted.
  - Changes on in_a/in_b after accept do not affect the in-flight result.
- Arithmetic: unsigned; the stage does not modify the product, it only samples product_i at the capture edge.

Test Plan:
- Basic latency: SETTLE_CYCLES=2, out_ready=1, accept in_a=3, in_b=5 at edge T -> out_valid high after edge T+2, out_product=0x000000000000000F, busy low after edge T+2.
- Max values: in_a=in_b=0xFFFFFFFF -> out_product=0xFFFFFFFE00000001. Also in_a=0x80000000, in_b=2 -> 0x0000000100000000.
- Backpressure: out_ready=0, issue 3 ops (2*3, 4*5, 6*7) -> first two buffered, in_ready stays 0 with the third pending. Raise out_ready -> outputs 6, 20, 42 in order, then the third op is accepted.
- Simultaneous capture/pop: count=1 with out_ready=1 on the capture edge -> count stays 1, ordering preserved, no duplicate or dropped result.
- Reset mid-operation: assert rst_n low during SETTLE of 7*9 -> all outputs 0 immediately. After release, accept 2*2 -> only 4 appears; 63 never appears.
- Operand hold: change in_a/in_b every cycle after accepting 0x10000*0x10000 -> result is 0x0000000100000000 and mplier_o/mcand_o are stable until the next accept.
